// File: rtl/fifo_serial_tx.sv
// ---------------------------------------------------------------------------
// fifo_serial_tx
//   Drain-side consumer for the FIFO read port. It pops one word at a time
//   and sends it as an asynchronous serial frame: start bit (0), data LSB
//   first, optional parity bit, stop bit (1). Every bit lasts clks_per_bit
//   clock cycles.
//
// Parameters
//   bits          data word width (must match the FIFO word width)
//   clks_per_bit  clock cycles per serial bit (>= 1)
//   parity        0 = none, 1 = even, 2 = odd
//
// Ports
//   clk         input   system clock, rising edge
//   rst         input   synchronous active-high reset
//   en          input   transmit enable; only gates the start of new frames
//   fifo_dout   input   FIFO head word, valid while fifo_pndng = 1
//   fifo_pndng  input   FIFO non-empty
//   fifo_pop    output  one-cycle pop request per word consumed
//   tx          output  serial line, idle high, registered
//   busy        output  high while a frame is in progress, registered
// ---------------------------------------------------------------------------
module fifo_serial_tx #(
    parameter int bits         = 8,
    parameter int clks_per_bit = 16,
    parameter int parity       = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [bits-1:0] fifo_dout,
    input  logic            fifo_pndng,
    output logic            fifo_pop,
    output logic            tx,
    output logic            busy
);

    localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int BW = (bits > 1) ? $clog2(bits) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(clks_per_bit - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(bits - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   idx_q, idx_d;
    logic [bits-1:0] shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            last_tick_s;
    logic            load_s;

    // Parity bit for a word: even parity is the XOR of all bits, odd is its inverse.
    function automatic logic parity_f(input logic [bits-1:0] d);
        if (parity == 2) begin
            parity_f = ~(^d);
        end else begin
            parity_f = ^d;
        end
    endfunction

    // Next-state, load decode and next registered output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;

        last_tick_s = (cnt_q == CNT_LAST);
        // A new word is taken from IDLE, or on the final STOP cycle so that
        // consecutive frames run back to back. Reset suppresses the pop.
        load_s = ~rst & en & fifo_pndng &
                 ((state_q == S_IDLE) | ((state_q == S_STOP) & last_tick_s));

        case (state_q)
            S_IDLE: begin
                if (load_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = fifo_dout;
                    par_d   = parity_f(fifo_dout);
                end else begin
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (last_tick_s) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (last_tick_s) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = (parity != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + BW'(1);
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (last_tick_s) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (last_tick_s) begin
                    cnt_d = '0;
                    if (load_s) begin
                        state_d = S_START;
                        idx_d   = '0;
                        shift_d = fifo_dout;
                        par_d   = parity_f(fifo_dout);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The line level follows the state being entered so tx stays
        // aligned with the registered state.
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase

        busy_d   = (state_d != S_IDLE);
        fifo_pop = load_s;
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
